ra_cfg_ctl: RTL and testbench

RA_CFG_CTL -- requirements
Module: ra_cfg_ctl

---
 rtl/ra_cfg_ctl_pkg.sv | 27 ++
 rtl/ra_cfg_arb.sv | 36 +++
 rtl/ra_cfg_ctl.sv | 127 ++++++++++++
 tb/tb_ra_cfg_ctl.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ra_cfg_ctl_pkg.sv
// RA config write controller: shared state type and round-robin helper.
// Falls back to a 16-bit config word when the DDR width macro is absent.
`ifndef LCBDDR_CONFIGWIDTH
`define LCBDDR_CONFIGWIDTH 16
`endif

package ra_cfg_ctl_pkg;

    localparam int CFG_WIDTH = `LCBDDR_CONFIGWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_WRITE,
        ST_SETTLE
    } cfg_state_t;

    // {b_ok, a_ok}: a requester never sees its own valid
    function automatic logic [1:0] rr_rdy(
        input logic a_val,
        input logic b_val,
        input logic last_b
    );
        return {!a_val || !last_b, !b_val || last_b};
    endfunction

endpackage

// File: rtl/ra_cfg_arb.sv
// Two-way round-robin arbiter for the config write controller.
// Holds the last-grant flop; B is "last" out of reset so A wins first.
module ra_cfg_arb
    import ra_cfg_ctl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic a_val,
    input  logic b_val,
    output logic a_rdy,
    output logic b_rdy,
    output logic a_hs,
    output logic b_hs
);

    logic       last_b;
    logic [1:0] pre;

    assign pre   = rr_rdy(a_val, b_val, last_b);
    assign a_rdy = en && pre[0];
    assign b_rdy = en && pre[1];
    assign a_hs  = a_val && a_rdy;
    assign b_hs  = b_val && b_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_b <= 1'b1;
        end else if (a_hs) begin
            last_b <= 1'b0;
        end else if (b_hs) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/ra_cfg_ctl.sv
// Config write controller: arbitrates two requesters onto a register
// strobe bus and runs an init sweep, with settle time after every write.
module ra_cfg_ctl
    import ra_cfg_ctl_pkg::*;
#(
    parameter int              NREGS   = 4,
    parameter int              ADRW    = 2,
    parameter int              CFGW    = CFG_WIDTH,
    parameter int              SETTLE  = 3,
    parameter logic [CFGW-1:0] INITVAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_start,
    input  logic             a_val,
    output logic             a_rdy,
    input  logic [ADRW-1:0]  a_adr,
    input  logic [CFGW-1:0]  a_dat,
    input  logic             b_val,
    output logic             b_rdy,
    input  logic [ADRW-1:0]  b_adr,
    input  logic [CFGW-1:0]  b_dat,
    output logic [NREGS-1:0] cfg_wr,
    output logic [CFGW-1:0]  cfg_dat,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] SLAST =
        (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [3:0] LAST_IDX = 4'(NREGS - 1);

    cfg_state_t state;
    logic [3:0] cnt;
    logic [3:0] idx;
    logic       sweep;
    logic       en;
    logic       a_hs;
    logic       b_hs;
    logic       fin;
    logic       more;

    // Out-of-range targets decode to an all-zero strobe
    function automatic logic [NREGS-1:0] sel(input int k);
        logic [NREGS-1:0] s;
        s = '0;
        for (int i = 0; i < NREGS; i++) begin
            s[i] = (k == i);
        end
        return s;
    endfunction

    assign en   = (state == ST_IDLE) && !init_start;
    assign busy = (state != ST_IDLE);
    assign fin  = (SETTLE == 0) ||
                  ((state == ST_SETTLE) && (cnt == SLAST));
    assign more = sweep && (idx != LAST_IDX);

    ra_cfg_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a_val (a_val),
        .b_val (b_val),
        .a_rdy (a_rdy),
        .b_rdy (b_rdy),
        .a_hs  (a_hs),
        .b_hs  (b_hs)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cfg_wr  <= '0;
            cfg_dat <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            sweep   <= 1'b0;
        end else begin
            done   <= 1'b0;
            cfg_wr <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (init_start) begin
                        state   <= ST_INIT;
                        sweep   <= 1'b1;
                        idx     <= '0;
                        cfg_wr  <= sel(0);
                        cfg_dat <= INITVAL;
                    end else if (a_hs) begin
                        state  <= ST_WRITE;
                        cfg_wr <= sel(int'(a_adr));
                        if (int'(a_adr) < NREGS) begin
                            cfg_dat <= a_dat;
                        end
                    end else if (b_hs) begin
                        state  <= ST_WRITE;
                        cfg_wr <= sel(int'(b_adr));
                        if (int'(b_adr) < NREGS) begin
                            cfg_dat <= b_dat;
                        end
                    end
                end
                default: begin
                    if (!fin) begin
                        state <= ST_SETTLE;
                        cnt   <= (state == ST_SETTLE) ?
                                 cnt + 4'd1 : 4'd0;
                    end else if (more) begin
                        state   <= ST_INIT;
                        cnt     <= '0;
                        idx     <= idx + 4'd1;
                        cfg_wr  <= sel(int'(idx) + 1);
                        cfg_dat <= INITVAL;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        sweep <= 1'b0;
                        done  <= sweep;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ra_cfg_ctl.sv
// Bench for ra_cfg_ctl: directed scenarios plus random traffic,
// checked against a transaction-timeline reference model.
module tb_ra_cfg_ctl;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int W  = 16;
    localparam int S  = 3;
    localparam logic [W-1:0] INITV = 16'hA5C3;

    logic         clk;
    logic         reset;
    logic         init_start;
    logic         a_val, b_val;
    logic [AW-1:0] a_adr, b_adr;
    logic [W-1:0] a_dat, b_dat;
    logic         a_rdy, b_rdy;
    logic [N-1:0] cfg_wr;
    logic [W-1:0] cfg_dat;
    logic         busy, done;

    logic         z_a_val;
    logic [1:0]   z_a_adr;
    logic [W-1:0] z_a_dat;
    logic         z_b_val;
    logic [1:0]   z_b_adr;
    logic [W-1:0] z_b_dat;
    logic         z_init;
    logic         z_a_rdy, z_b_rdy;
    logic [N-1:0] z_cfg_wr;
    logic [W-1:0] z_cfg_dat;
    logic         z_busy, z_done;

    int n_cmp = 0;
    int n_bad = 0;

    ra_cfg_ctl #(
        .NREGS(N), .ADRW(AW), .CFGW(W),
        .SETTLE(S), .INITVAL(INITV)
    ) dut (
        .clk(clk), .reset(reset),
        .init_start(init_start),
        .a_val(a_val), .a_rdy(a_rdy),
        .a_adr(a_adr), .a_dat(a_dat),
        .b_val(b_val), .b_rdy(b_rdy),
        .b_adr(b_adr), .b_dat(b_dat),
        .cfg_wr(cfg_wr), .cfg_dat(cfg_dat),
        .busy(busy), .done(done)
    );

    ra_cfg_ctl #(
        .NREGS(N), .ADRW(2), .CFGW(W), .SETTLE(0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .init_start(z_init),
        .a_val(z_a_val), .a_rdy(z_a_rdy),
        .a_adr(z_a_adr), .a_dat(z_a_dat),
        .b_val(z_b_val), .b_rdy(z_b_rdy),
        .b_adr(z_b_adr), .b_dat(z_b_dat),
        .cfg_wr(z_cfg_wr), .cfg_dat(z_cfg_dat),
        .busy(z_busy), .done(z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a timeline of future strobes/data/done pulses
    int           now;
    int           m_free;
    bit           m_last_b;
    logic [N-1:0] wr_at[int];
    logic [W-1:0] dat_at[int];
    bit           done_at[int];
    logic         exp_a_rdy, exp_b_rdy;
    logic [N-1:0] e_wr;
    logic [W-1:0] e_dat;
    logic         e_done, e_busy;

    function automatic void model_reset();
        now = 0;
        m_free = 0;
        m_last_b = 1'b1;
        wr_at.delete();
        dat_at.delete();
        done_at.delete();
        e_wr = '0;
        e_dat = '0;
        e_done = 1'b0;
        e_busy = 1'b0;
    endfunction

    function automatic void model_accept(
        input logic [AW-1:0] adr,
        input logic [W-1:0]  dat
    );
        logic [N-1:0] m;
        m = '0;
        if (int'(adr) < N) begin
            m[int'(adr)] = 1'b1;
            dat_at[now + 1] = dat;
        end
        wr_at[now + 1] = m;
        m_free = now + 2 + S;
    endfunction

    function automatic void model_pre();
        bit idle;
        logic [N-1:0] m;
        idle = (now >= m_free);
        exp_a_rdy = idle && !init_start && (!b_val || m_last_b);
        exp_b_rdy = idle && !init_start && (!a_val || !m_last_b);
        if (idle && init_start) begin
            for (int k = 0; k < N; k++) begin
                m = '0;
                m[k] = 1'b1;
                wr_at[now + 1 + k * (S + 1)] = m;
                dat_at[now + 1 + k * (S + 1)] = INITV;
            end
            done_at[now + 1 + N * (S + 1)] = 1'b1;
            m_free = now + 1 + N * (S + 1);
        end else if (a_val && exp_a_rdy) begin
            model_accept(a_adr, a_dat);
            m_last_b = 1'b0;
        end else if (b_val && exp_b_rdy) begin
            model_accept(b_adr, b_dat);
            m_last_b = 1'b1;
        end
    endfunction

    function automatic void model_post();
        now++;
        e_wr = wr_at.exists(now) ? wr_at[now] : '0;
        if (dat_at.exists(now)) e_dat = dat_at[now];
        e_done = done_at.exists(now);
        e_busy = (now < m_free);
    endfunction

    task automatic drive(
        input logic          av,
        input logic [AW-1:0] aa,
        input logic [W-1:0]  ad,
        input logic          bv,
        input logic [AW-1:0] ba,
        input logic [W-1:0]  bd,
        input logic          ini
    );
        a_val = av; a_adr = aa; a_dat = ad;
        b_val = bv; b_adr = ba; b_dat = bd;
        init_start = ini;
        #1;
        model_pre();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_post();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        a_val = 0; b_val = 0; init_start = 0;
        a_adr = 0; b_adr = 0; a_dat = 0; b_dat = 0;
        z_a_val = 0; z_a_adr = 0; z_a_dat = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #3;
        if (cfg_wr !== '0 || cfg_dat !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_outputs: got wr=%b dat=%h busy=%b done=%b want all 0",
                     cfg_wr, cfg_dat, busy, done);
        end
        n_cmp++;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
            if (cfg_wr !== e_wr || busy !== e_busy) begin
                n_bad++;
                $display("FAIL rst_no_sweep: got wr=%b busy=%b want wr=%b busy=%b",
                         cfg_wr, busy, e_wr, e_busy);
            end
            n_cmp++;
        end
    endtask

    task automatic test_single_write();
        int nb;
        do_reset();
        drive(1, 3'd2, 16'h0005, 0, 0, 0, 0);
        if (a_rdy !== exp_a_rdy) begin
            n_bad++;
            $display("FAIL sw_a_rdy: got %b want %b", a_rdy, exp_a_rdy);
        end
        n_cmp++;
        tick();
        if (cfg_wr !== e_wr || cfg_dat !== e_dat) begin
            n_bad++;
            $display("FAIL sw_strobe: got wr=%b dat=%h want wr=%b dat=%h",
                     cfg_wr, cfg_dat, e_wr, e_dat);
        end
        n_cmp++;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) nb++;
            if (cfg_wr !== e_wr) begin
                n_bad++;
                $display("FAIL sw_wr_cyc: got %b want %b", cfg_wr, e_wr);
            end
            n_cmp++;
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        if (nb !== S + 1) begin
            n_bad++;
            $display("FAIL sw_busy_len: got %0d want %0d", nb, S + 1);
        end
        n_cmp++;
    endtask

    task automatic test_round_robin();
        string g;
        int    t[$];
        g = "";
        do_reset();
        for (int i = 0; i < 22; i++) begin
            drive(1, AW'(i % N), W'($urandom), 1,
                  AW'((i + 1) % N), W'($urandom), 0);
            if (a_rdy !== exp_a_rdy || b_rdy !== exp_b_rdy) begin
                n_bad++;
                $display("FAIL rr_rdy: got a=%b b=%b want a=%b b=%b",
                         a_rdy, b_rdy, exp_a_rdy, exp_b_rdy);
            end
            n_cmp++;
            if (a_rdy === 1'b1) begin g = {g, "A"}; t.push_back(i); end
            else if (b_rdy === 1'b1) begin g = {g, "B"}; t.push_back(i); end
            tick();
            if (cfg_wr !== e_wr || cfg_dat !== e_dat) begin
                n_bad++;
                $display("FAIL rr_strobe: got wr=%b dat=%h want wr=%b dat=%h",
                         cfg_wr, cfg_dat, e_wr, e_dat);
            end
            n_cmp++;
        end
        if (g.len() < 4 || g.substr(0, 3) != "ABAB") begin
            n_bad++;
            $display("FAIL rr_order: got %s want ABAB...", g);
        end
        n_cmp++;
        if (t.size() < 2 || t[1] - t[0] != S + 2) begin
            n_bad++;
            $display("FAIL rr_spacing: got %0d grants want period %0d",
                     t.size(), S + 2);
        end
        n_cmp++;
    endtask

    task automatic test_init_sweep();
        logic [N-1:0] seen[$];
        int ts[$];
        int nd;
        bit acc;
        bit ok;
        nd = 0; acc = 0;
        do_reset();
        drive(1, 3'd1, 16'h1234, 0, 0, 0, 1);
        if (a_rdy !== exp_a_rdy) begin
            n_bad++;
            $display("FAIL init_blocks_a: got %b want %b", a_rdy, exp_a_rdy);
        end
        n_cmp++;
        tick();
        for (int i = 0; i < 40 && !acc; i++) begin
            drive(1, 3'd1, 16'h1234, 0, 0, 0, 0);
            if (cfg_wr !== e_wr || cfg_dat !== e_dat ||
                done !== e_done || a_rdy !== exp_a_rdy) begin
                n_bad++;
                $display("FAIL init_cyc: got wr=%b dat=%h done=%b rdy=%b want %b %h %b %b",
                         cfg_wr, cfg_dat, done, a_rdy,
                         e_wr, e_dat, e_done, exp_a_rdy);
            end
            n_cmp++;
            if (cfg_wr !== '0) begin
                seen.push_back(cfg_wr);
                ts.push_back(i);
            end
            if (done === 1'b1) begin
                nd++;
                if (a_rdy === 1'b1) acc = 1;
            end
            if (!acc) tick();
        end
        ok = (seen.size() == N);
        for (int k = 0; ok && k < N; k++) begin
            if (seen[k] !== N'(1 << k)) ok = 0;
            if (k > 0 && ts[k] - ts[k-1] != S + 1) ok = 0;
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL init_order: got %0d strobes want %0d one-hot every %0d",
                     seen.size(), N, S + 1);
        end
        n_cmp++;
        if (nd !== 1 || !acc) begin
            n_bad++;
            $display("FAIL init_done: got %0d pulses acc=%0d want 1 acc=1", nd, acc);
        end
        n_cmp++;
    endtask

    task automatic test_out_of_range();
        int nb;
        logic [N-1:0] orw;
        nb = 0; orw = '0;
        do_reset();
        drive(0, 0, 0, 1, 3'd5, 16'hBEEF, 0);
        if (b_rdy !== exp_b_rdy) begin
            n_bad++;
            $display("FAIL oor_b_rdy: got %b want %b", b_rdy, exp_b_rdy);
        end
        n_cmp++;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) nb++;
            orw = orw | cfg_wr;
            if (cfg_dat !== e_dat) begin
                n_bad++;
                $display("FAIL oor_dat: got %h want %h", cfg_dat, e_dat);
            end
            n_cmp++;
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        if (orw !== '0 || nb !== S + 1) begin
            n_bad++;
            $display("FAIL oor_strobe: got wr=%b busy=%0d want wr=0 busy=%0d",
                     orw, nb, S + 1);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_init();
        bit hit;
        hit = 0;
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 20 && !hit; i++) begin
            if (e_wr === 4'b0100) hit = 1;
            else begin
                drive(0, 0, 0, 0, 0, 0, 0);
                tick();
            end
        end
        if (!hit || cfg_wr !== e_wr) begin
            n_bad++;
            $display("FAIL mid_idx2: got %b want %b reached=%0d", cfg_wr, e_wr, hit);
        end
        n_cmp++;
        #2 reset = 1'b0;
        #1;
        if (cfg_wr !== '0 || cfg_dat !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_async: got wr=%b dat=%h busy=%b done=%b want all 0",
                     cfg_wr, cfg_dat, busy, done);
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
            if (cfg_wr !== e_wr || busy !== e_busy || done !== e_done) begin
                n_bad++;
                $display("FAIL mid_resume: got wr=%b busy=%b done=%b want %b %b %b",
                         cfg_wr, busy, done, e_wr, e_busy, e_done);
            end
            n_cmp++;
        end
    endtask

    task automatic test_settle0();
        logic [W-1:0] d;
        logic [N-1:0] xw;
        int ns;
        ns = 0; d = '0;
        do_reset();
        z_a_val = 1'b1;
        z_a_adr = 2'd1;
        for (int i = 0; i < 12; i++) begin
            z_a_dat = W'($urandom);
            #1;
            if (z_a_rdy !== ((i % 2) == 0)) begin
                n_bad++;
                $display("FAIL s0_rdy: got %b want %b", z_a_rdy, (i % 2) == 0);
            end
            n_cmp++;
            if ((i % 2) == 0) d = z_a_dat;
            @(posedge clk);
            #1;
            xw = ((i % 2) == 0) ? 4'b0010 : 4'b0000;
            if (z_cfg_wr !== xw || z_busy !== ((i % 2) == 0) ||
                z_cfg_dat !== d) begin
                n_bad++;
                $display("FAIL s0_cyc: got wr=%b busy=%b dat=%h want %b %b %h",
                         z_cfg_wr, z_busy, z_cfg_dat, xw, (i % 2) == 0, d);
            end
            n_cmp++;
            if (z_cfg_wr !== '0) ns++;
            @(negedge clk);
        end
        z_a_val = 1'b0;
        if (ns !== 6) begin
            n_bad++;
            $display("FAIL s0_count: got %0d want 6", ns);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), AW'($urandom), W'($urandom),
                  1'($urandom), AW'($urandom), W'($urandom),
                  ($urandom % 25) == 0);
            if (a_rdy !== exp_a_rdy || b_rdy !== exp_b_rdy) begin
                n_bad++;
                $display("FAIL rnd_rdy @%0d: got a=%b b=%b want a=%b b=%b",
                         i, a_rdy, b_rdy, exp_a_rdy, exp_b_rdy);
            end
            n_cmp++;
            tick();
            if (cfg_wr !== e_wr || cfg_dat !== e_dat ||
                done !== e_done || busy !== e_busy) begin
                n_bad++;
                $display("FAIL rnd_out @%0d: got wr=%b dat=%h done=%b busy=%b want %b %h %b %b",
                         i, cfg_wr, cfg_dat, done, busy,
                         e_wr, e_dat, e_done, e_busy);
            end
            n_cmp++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        init_start = 0;
        a_val = 0; b_val = 0;
        a_adr = 0; b_adr = 0; a_dat = 0; b_dat = 0;
        z_a_val = 0; z_a_adr = 0; z_a_dat = 0;
        z_b_val = 0; z_b_adr = 0; z_b_dat = 0;
        z_init = 0;
        model_reset();
        test_reset();
        test_single_write();
        test_round_robin();
        test_init_sweep();
        test_out_of_range();
        test_reset_mid_init();
        test_settle0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
